// File: rtl/fdma_wr_arbiter_pkg.sv
// Shared definitions for the FDMA write-channel arbiter: bus widths, FSM states
// and the modular index helper used by the round-robin picker.
package fdma_pkg;

  localparam int FDMA_ADDR_W = 32;
  localparam int FDMA_SIZE_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_XFER  = 2'd3
  } arb_state_t;

  // (base + off) mod n, used to rotate and un-rotate requester indices.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/fdma_wr_arbiter_if.sv
// Requester-side and FDMA-side signals of the write arbiter, bundled with
// modports for the arbiter (master) and its environment (slave).
interface fdma_wr_arbiter_if
  import fdma_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 128
);

  // Handshake: req_areq[i] is a one-cycle request pulse with no backpressure;
  // the arbiter answers with a one-cycle pkg_wr_areq, after which the FDMA
  // master drives pkg_wr_en per consumed beat and pkg_wr_last on the final beat.
  logic [NREQ-1:0]             req_areq;
  logic [NREQ*FDMA_ADDR_W-1:0] req_addr;
  logic [NREQ*FDMA_SIZE_W-1:0] req_size;
  logic [NREQ*DATA_W-1:0]      req_data;
  logic [NREQ-1:0]             req_wr_en;
  logic [NREQ-1:0]             req_wr_last;

  logic                        pkg_wr_areq;
  logic                        pkg_wr_en;
  logic                        pkg_wr_last;
  logic [FDMA_ADDR_W-1:0]      pkg_wr_addr;
  logic [FDMA_SIZE_W-1:0]      pkg_wr_size;
  logic [DATA_W-1:0]           pkg_wr_data;

  modport master (
    input  req_areq, req_addr, req_size, req_data,
    input  pkg_wr_en, pkg_wr_last,
    output req_wr_en, req_wr_last,
    output pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_data
  );

  modport slave (
    output req_areq, req_addr, req_size, req_data,
    output pkg_wr_en, pkg_wr_last,
    input  req_wr_en, req_wr_last,
    input  pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_data
  );

endinterface

// File: rtl/fdma_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index strictly after
// last_grant, wrapping modulo NREQ.
module rr_pick
  import fdma_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         pending,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] rotated;
  logic [IW-1:0]   first_off;

  // rotated[0] is the requester right after last_grant
  always_comb begin
    rotated = '0;
    for (int k = 0; k < NREQ; k++) begin
      rotated[k] = pending[IW'(rr_index(int'(last_grant), k + 1, NREQ))];
    end
  end

  always_comb begin
    first_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rotated[k]) first_off = IW'(k);
    end
  end

  assign valid = |pending;
  assign idx   = IW'(rr_index(int'(last_grant), int'(first_off) + 1, NREQ));

endmodule

// File: rtl/fdma_wr_arbiter.sv
// Round-robin arbiter sharing one FDMA write channel among NREQ packet writers:
// latches request pulses, grants one requester per burst and routes strobes back.
module fdma_wr_arbiter
  import fdma_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    ui_clk,
  input  logic                    ui_rstn,
  fdma_wr_arbiter_if.master       bus,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [31:0]             burst_cnt,
  output arb_state_t              fsm_state
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t state, state_nxt;

  logic [NREQ-1:0]        pending;
  logic [NREQ-1:0]        grant_clr;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          last_grant;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [FDMA_ADDR_W-1:0] addr_q;
  logic [FDMA_SIZE_W-1:0] size_q;
  logic [FDMA_ADDR_W-1:0] pick_addr;
  logic [FDMA_SIZE_W-1:0] pick_size;
  logic [WDW-1:0]         wd_cnt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Slice selection is written as a constant-index mux to keep widths exact.
  always_comb begin
    pick_addr = '0;
    pick_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_addr = bus.req_addr[i*FDMA_ADDR_W +: FDMA_ADDR_W];
        pick_size = bus.req_size[i*FDMA_SIZE_W +: FDMA_SIZE_W];
      end
    end
  end

  always_comb begin
    bus.pkg_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) bus.pkg_wr_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    grant_clr = '0;
    if (state == S_ARB && pick_valid) grant_clr[pick_idx] = 1'b1;
  end

  // A pulse landing in the same cycle as its grant keeps the request pending.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_clr) | bus.req_areq;
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|pending) state_nxt = S_ARB;
      S_ARB:   state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_XFER;
      S_XFER:  if (bus.pkg_wr_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes reach only the granted requester, and only while a burst is live.
  always_comb begin
    bus.req_wr_en   = '0;
    bus.req_wr_last = '0;
    if (state == S_XFER) begin
      bus.req_wr_en[grant]   = bus.pkg_wr_en;
      bus.req_wr_last[grant] = bus.pkg_wr_last;
    end
    bus.pkg_wr_areq = (state == S_ISSUE);
    busy            = (state == S_ISSUE) || (state == S_XFER);
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      grant      <= '0;
      last_grant <= IW'(NREQ - 1);
      addr_q     <= '0;
      size_q     <= '0;
    end else if (state == S_ARB && pick_valid) begin
      grant      <= pick_idx;
      last_grant <= pick_idx;
      addr_q     <= pick_addr;
      size_q     <= pick_size;
    end
  end

  // Watchdog only flags a stuck burst; the transfer itself is never aborted.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_XFER && wd_cnt != WDW'(TIMEOUT_CYC)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WDW'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      burst_cnt <= '0;
    end else if (state == S_XFER && bus.pkg_wr_last) begin
      burst_cnt <= burst_cnt + 32'd1;
    end
  end

  assign bus.pkg_wr_addr = addr_q;
  assign bus.pkg_wr_size = size_q;
  assign grant_id        = 3'(grant);
  assign fsm_state       = state;

endmodule

// File: tb/tb_fdma_wr_arbiter.sv
// Directed bench for fdma_wr_arbiter: a transaction-level model of pending
// requests and round-robin grants checked every cycle, plus literal expectations.
module tb_fdma_wr_arbiter;
  import fdma_pkg::*;

  localparam int NREQ        = 4;
  localparam int DATA_W      = 128;
  localparam int TIMEOUT_CYC = 40;

  logic        ui_clk  = 1'b0;
  logic        ui_rstn = 1'b0;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  logic [31:0] burst_cnt;
  arb_state_t  fsm_state;

  fdma_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  fdma_wr_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ui_clk      (ui_clk),
    .ui_rstn     (ui_rstn),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout),
    .burst_cnt   (burst_cnt),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 ui_clk = ~ui_clk;

  int cyc = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000ns");
    $fatal(1, "simulation time limit reached");
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] grant_log[$];
  int en_cnt[NREQ];

  bit          m_pend[NREQ];
  int          m_since[NREQ];
  int          m_lastp[NREQ];
  int          m_last_grant;
  int          m_grant;
  bit          m_xfer;
  int          m_last_end;
  int          m_wd;
  bit          m_err;
  logic [31:0] m_bursts;
  logic [31:0] prev_addr[NREQ];
  logic [31:0] prev_size[NREQ];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int g);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (i == g) r = bus.req_data[i*DATA_W +: DATA_W];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i]  = 1'b0;
      m_since[i] = 0;
      m_lastp[i] = -100;
    end
    m_last_grant = NREQ - 1;
    m_grant      = 0;
    m_xfer       = 1'b0;
    m_last_end   = -100;
    m_wd         = 0;
    m_err        = 1'b0;
    m_bursts     = '0;
  endtask

  // A pulse in cycle p is visible as pending from p+1; an arbitration round
  // decides in the cycle before pkg_wr_areq, so at areq cycle c only pulses
  // from cycles <= c-2 compete. A new round needs a pulse >= 3 cycles old and
  // the previous burst to have ended >= 3 cycles earlier.
  task automatic model_loop();
    bit               e_areq;
    int               eg;
    int               c;
    logic [NREQ-1:0]  e_en;
    logic [NREQ-1:0]  e_last;
    forever begin
      @(negedge ui_clk);
      c = cyc;
      if (!ui_rstn) begin
        model_reset();
      end else begin
        e_areq = 1'b0;
        if (!m_xfer && m_last_end <= c - 3) begin
          for (int i = 0; i < NREQ; i++) if (m_pend[i] && m_since[i] <= c - 3) e_areq = 1'b1;
        end
        if (e_areq) begin
          eg = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last_grant + k) % NREQ;
            if (eg < 0 && m_pend[j] && m_since[j] <= c - 2) eg = j;
          end
          m_grant = eg;
        end

        check("areq", 128'(bus.pkg_wr_areq), 128'(e_areq));
        check("grant_id", 128'(grant_id), 128'(m_grant));
        if (e_areq) begin
          check("addr", 128'(bus.pkg_wr_addr), 128'(prev_addr[m_grant]));
          check("size", 128'(bus.pkg_wr_size), 128'(prev_size[m_grant]));
        end
        for (int i = 0; i < NREQ; i++) begin
          e_en[i]   = m_xfer && (i == m_grant) && bus.pkg_wr_en;
          e_last[i] = m_xfer && (i == m_grant) && bus.pkg_wr_last;
        end
        check("req_wr_en", 128'(bus.req_wr_en), 128'(e_en));
        check("req_wr_last", 128'(bus.req_wr_last), 128'(e_last));
        check("wr_data", 128'(bus.pkg_wr_data), 128'(data_of(m_grant)));
        check("busy", 128'(busy), 128'(e_areq || m_xfer));
        check("burst_cnt", 128'(burst_cnt), 128'(m_bursts));
        check("err_timeout", 128'(err_timeout), 128'(m_err));

        if (bus.pkg_wr_areq) grant_log.push_back(grant_id);
        for (int i = 0; i < NREQ; i++) if (bus.req_wr_en[i]) en_cnt[i]++;

        if (e_areq) begin
          if (m_lastp[m_grant] == c - 1) m_since[m_grant] = c - 1;
          else m_pend[m_grant] = 1'b0;
          m_last_grant = m_grant;
          m_wd = 0;
        end
        if (m_xfer) begin
          if (m_wd < TIMEOUT_CYC) m_wd++;
          if (m_wd == TIMEOUT_CYC) m_err = 1'b1;
          if (bus.pkg_wr_last) begin
            m_bursts   = m_bursts + 32'd1;
            m_xfer     = 1'b0;
            m_last_end = c;
          end
        end
        if (e_areq) m_xfer = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_areq[i]) begin
            if (!m_pend[i]) begin
              m_pend[i]  = 1'b1;
              m_since[i] = c;
            end
            m_lastp[i] = c;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        prev_addr[i] = bus.req_addr[i*32 +: 32];
        prev_size[i] = bus.req_size[i*32 +: 32];
      end
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic pulse(input logic [NREQ-1:0] m, output int at);
    bus.req_areq = m;
    at = cyc;
    tick(1);
    bus.req_areq = '0;
  endtask

  task automatic wait_areq(output int at);
    at = -1;
    for (int k = 0; k < 200 && at < 0; k++) begin
      @(negedge ui_clk);
      if (bus.pkg_wr_areq) at = cyc;
    end
    check("areq_seen", 128'(at >= 0), 128'(1));
    tick(1);
  endtask

  task automatic xfer(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pkg_wr_en   = 1'b1;
      bus.pkg_wr_last = (k == n - 1);
      tick(1);
    end
    bus.pkg_wr_en   = 1'b0;
    bus.pkg_wr_last = 1'b0;
  endtask

  task automatic serve(input int n);
    int at;
    wait_areq(at);
    xfer(n);
  endtask

  task automatic do_reset();
    ui_rstn = 1'b0;
    tick(3);
    ui_rstn = 1'b1;
    tick(1);
  endtask

  task automatic check_log(input string name, input int base);
    check({name, "_count"}, 128'(grant_log.size() - base), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < grant_log.size()) check(name, 128'(grant_log[base + k]), 128'(exp_q[k]));
    end
  endtask

  initial begin
    int p, q, at, lb, b0, b1, b2, b3;
    logic [DATA_W-1:0] a5;
    a5 = {16{8'hA5}};
    bus.req_areq    = '0;
    bus.pkg_wr_en   = 1'b0;
    bus.pkg_wr_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*32 +: 32] = 32'h0100_0000 + 32'(i) * 32'h100;
      bus.req_size[i*32 +: 32] = 32'd16 + 32'(i);
      bus.req_data[i*DATA_W +: DATA_W] = {4{32'h1111_1111 * 32'(i + 1)}};
      en_cnt[i] = 0;
    end
    model_reset();
    fork
      model_loop();
    join_none

    // reset state
    ui_rstn = 1'b0;
    tick(3);
    check("rst_areq", 128'(bus.pkg_wr_areq), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(grant_id), 128'(0));
    check("rst_burst_cnt", 128'(burst_cnt), 128'(0));
    check("rst_err", 128'(err_timeout), 128'(0));
    check("rst_addr", 128'(bus.pkg_wr_addr), 128'(0));
    check("rst_size", 128'(bus.pkg_wr_size), 128'(0));
    check("rst_wr_en", 128'(bus.req_wr_en), 128'(0));
    check("rst_state", 128'(fsm_state), 128'(S_IDLE));
    ui_rstn = 1'b1;
    tick(2);

    // stray FDMA strobes while idle must be ignored
    bus.pkg_wr_en   = 1'b1;
    bus.pkg_wr_last = 1'b1;
    tick(2);
    bus.pkg_wr_en   = 1'b0;
    bus.pkg_wr_last = 1'b0;
    tick(1);

    // single request on requester 2
    bus.req_addr[2*32 +: 32] = 32'h0000_1000;
    bus.req_size[2*32 +: 32] = 32'd8;
    b2 = en_cnt[2];
    pulse(4'b0100, p);
    wait_areq(at);
    check("t1_latency", 128'(at - p), 128'(3));
    check("t1_addr", 128'(bus.pkg_wr_addr), 128'(32'h1000));
    check("t1_size", 128'(bus.pkg_wr_size), 128'(8));
    check("t1_grant", 128'(grant_id), 128'(2));
    xfer(8);
    tick(2);
    check("t1_beats", 128'(en_cnt[2] - b2), 128'(8));
    check("t1_burst_cnt", 128'(burst_cnt), 128'(1));

    // all four pulse together from a fresh reset
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*32 +: 32] = 32'h0000_2000 + 32'(i) * 32'h100;
    lb = grant_log.size();
    pulse(4'b1111, p);
    repeat (4) serve(3);
    tick(2);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    check_log("t2_order", lb);
    check("t2_burst_cnt", 128'(burst_cnt), 128'(4));

    // requester 1 re-pulses in the cycle it is being granted
    lb = grant_log.size();
    pulse(4'b0110, p);
    tick(1);
    pulse(4'b0010, q);
    check("t3_repulse_cycle", 128'(q - p), 128'(2));
    repeat (3) serve(2);
    tick(2);
    exp_q = '{3'd1, 3'd2, 3'd1};
    check_log("t3_order", lb);

    // data routing to requester 3
    bus.req_data[3*DATA_W +: DATA_W] = a5;
    b0 = en_cnt[0];
    b1 = en_cnt[1];
    b2 = en_cnt[2];
    b3 = en_cnt[3];
    pulse(4'b1000, p);
    wait_areq(at);
    check("t4_grant", 128'(grant_id), 128'(3));
    check("t4_data", 128'(bus.pkg_wr_data), 128'(a5));
    xfer(5);
    tick(2);
    check("t4_en0", 128'(en_cnt[0] - b0), 128'(0));
    check("t4_en1", 128'(en_cnt[1] - b1), 128'(0));
    check("t4_en2", 128'(en_cnt[2] - b2), 128'(0));
    check("t4_en3", 128'(en_cnt[3] - b3), 128'(5));

    // watchdog: last withheld across the timeout boundary
    pulse(4'b0001, p);
    wait_areq(at);
    tick(TIMEOUT_CYC - 1);
    check("t5_err_before", 128'(err_timeout), 128'(0));
    tick(1);
    check("t5_err_at", 128'(err_timeout), 128'(1));
    tick(5);
    check("t5_err_sticky", 128'(err_timeout), 128'(1));
    check("t5_still_busy", 128'(busy), 128'(1));
    xfer(1);
    tick(1);
    check("t5_idle", 128'(fsm_state), 128'(S_IDLE));
    check("t5_err_after", 128'(err_timeout), 128'(1));

    // asynchronous reset in the middle of a burst
    pulse(4'b0001, p);
    wait_areq(at);
    bus.pkg_wr_en = 1'b1;
    tick(2);
    pulse(4'b0100, q);
    #3;
    ui_rstn = 1'b0;
    #1;
    check("t6_wr_en", 128'(bus.req_wr_en), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_err", 128'(err_timeout), 128'(0));
    check("t6_burst_cnt", 128'(burst_cnt), 128'(0));
    check("t6_state", 128'(fsm_state), 128'(S_IDLE));
    bus.pkg_wr_en = 1'b0;
    tick(2);
    ui_rstn = 1'b1;
    lb = grant_log.size();
    tick(8);
    check("t6_pending_cleared", 128'(grant_log.size() - lb), 128'(0));
    pulse(4'b1111, p);
    serve(2);
    tick(2);
    exp_q = '{3'd0};
    check_log("t6_first_grant", lb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
